// File: rtl/game_sequencer.sv
// ============================================================================
//  Module   : game_sequencer
//  Purpose  : Game-flow controller (lives, score, state) gating the invaders
//             datapath; timers advance on vsync frame boundaries.
//             Optional macro EXTRA_LIFE_EN enables the one-shot bonus life.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module game_sequencer #(
    parameter int START_LIVES      = 3,
    parameter int POINTS_PER_ALIEN = 1,
    parameter int RESPAWN_FRAMES   = 90,
    parameter int WAVE_FRAMES      = 60,
    parameter int GAMEOVER_FRAMES  = 180,
    parameter int EXTRA_LIFE_SCORE = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       btn_start,
    input  logic       alien_hit,
    input  logic       player_hit,
    input  logic [5:0] aliens_left,
    input  logic       aliens_landed,
    output logic [2:0] state,
    output logic       run_en,
    output logic       formation_rst,
    output logic       cannon_rst,
    output logic [1:0] lives,
    output logic [7:0] score
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PLAYING    = 3'd1,
        S_DYING      = 3'd2,
        S_WAVE_CLEAR = 3'd3,
        S_GAME_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] c_start_lives = 2'(START_LIVES);
    localparam logic [8:0] c_points      = 9'(POINTS_PER_ALIEN);
    localparam logic [7:0] c_respawn     = 8'(RESPAWN_FRAMES);
    localparam logic [7:0] c_wave        = 8'(WAVE_FRAMES);
    localparam logic [7:0] c_gameover    = 8'(GAMEOVER_FRAMES);

    state_t     r_state;
    logic [2:0] r_vs_sync;
    logic [2:0] r_btn_sync;
    logic       r_frame_tick;
    logic       r_start_press;
    logic [7:0] r_frame_cnt;
    logic [8:0] w_score_sum;
    logic [7:0] w_score_next;

    assign state        = r_state;
    assign w_score_sum  = {1'b0, score} + c_points;
    assign w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

`ifdef EXTRA_LIFE_EN
    localparam logic [8:0] c_extra_score = 9'(EXTRA_LIFE_SCORE);
    logic r_bonus_avail;
    logic w_bonus_cross;
    assign w_bonus_cross = ({1'b0, score} < c_extra_score) &&
                           ({1'b0, w_score_next} >= c_extra_score);
`endif

    // Two-flop synchronizers plus an edge-detect stage, registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_sync     <= '0;
            r_btn_sync    <= '0;
            r_frame_tick  <= 1'b0;
            r_start_press <= 1'b0;
        end else begin
            r_vs_sync     <= {r_vs_sync[1:0], vsync};
            r_btn_sync    <= {r_btn_sync[1:0], btn_start};
            r_frame_tick  <= r_vs_sync[1] & ~r_vs_sync[2];
            r_start_press <= r_btn_sync[1] & ~r_btn_sync[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            run_en        <= 1'b0;
            formation_rst <= 1'b0;
            cannon_rst    <= 1'b0;
            lives         <= 2'd0;
            score         <= 8'd0;
            r_frame_cnt   <= 8'd0;
`ifdef EXTRA_LIFE_EN
            r_bonus_avail <= 1'b0;
`endif
        end else begin
            formation_rst <= 1'b0;
            cannon_rst    <= 1'b0;
            if (r_frame_tick && r_frame_cnt != 8'hFF)
                r_frame_cnt <= r_frame_cnt + 8'd1;

            // Every transition below also clears the frame counter
            case (r_state)
                S_IDLE: begin
                    if (r_start_press) begin
                        r_state       <= S_PLAYING;
                        run_en        <= 1'b1;
                        lives         <= c_start_lives;
                        score         <= 8'd0;
                        formation_rst <= 1'b1;
                        cannon_rst    <= 1'b1;
                        r_frame_cnt   <= 8'd0;
`ifdef EXTRA_LIFE_EN
                        r_bonus_avail <= 1'b1;
`endif
                    end
                end
                S_PLAYING: begin
                    if (alien_hit) begin
                        score <= w_score_next;
`ifdef EXTRA_LIFE_EN
                        if (r_bonus_avail && w_bonus_cross) begin
                            r_bonus_avail <= 1'b0;
                            if (lives != 2'd3)
                                lives <= lives + 2'd1;
                        end
`endif
                    end
                    if (aliens_landed) begin
                        r_state     <= S_GAME_OVER;
                        run_en      <= 1'b0;
                        lives       <= 2'd0;
                        r_frame_cnt <= 8'd0;
                    end else if (player_hit) begin
                        r_state     <= S_DYING;
                        run_en      <= 1'b0;
                        r_frame_cnt <= 8'd0;
                    end else if (aliens_left == 6'd0) begin
                        r_state     <= S_WAVE_CLEAR;
                        run_en      <= 1'b0;
                        r_frame_cnt <= 8'd0;
                    end
                end
                S_DYING: begin
                    if (r_frame_cnt >= c_respawn) begin
                        r_frame_cnt <= 8'd0;
                        if (lives <= 2'd1) begin
                            lives   <= 2'd0;
                            r_state <= S_GAME_OVER;
                        end else begin
                            lives      <= lives - 2'd1;
                            r_state    <= S_PLAYING;
                            run_en     <= 1'b1;
                            cannon_rst <= 1'b1;
                        end
                    end
                end
                S_WAVE_CLEAR: begin
                    if (r_frame_cnt >= c_wave) begin
                        r_frame_cnt   <= 8'd0;
                        r_state       <= S_PLAYING;
                        run_en        <= 1'b1;
                        formation_rst <= 1'b1;
                        cannon_rst    <= 1'b1;
                    end
                end
                S_GAME_OVER: begin
                    if (r_frame_cnt >= c_gameover) begin
                        r_frame_cnt <= 8'd0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    run_en      <= 1'b0;
                    r_frame_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
//  Module   : tb_game_sequencer
//  Purpose  : Directed self-checking bench for game_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_game_sequencer;

    logic       clk;
    logic       rst_n;
    logic       vsync;
    logic       btn_start;
    logic       alien_hit;
    logic       player_hit;
    logic [5:0] aliens_left;
    logic       aliens_landed;
    logic [2:0] state;
    logic       run_en;
    logic       formation_rst;
    logic       cannon_rst;
    logic [1:0] lives;
    logic [7:0] score;

    int errors = 0;
    int checks = 0;
    int n_frst = 0;
    int n_crst = 0;

    game_sequencer #(
        .START_LIVES      (3),
        .POINTS_PER_ALIEN (20),
        .RESPAWN_FRAMES   (4),
        .WAVE_FRAMES      (3),
        .GAMEOVER_FRAMES  (5),
        .EXTRA_LIFE_SCORE (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vsync         (vsync),
        .btn_start     (btn_start),
        .alien_hit     (alien_hit),
        .player_hit    (player_hit),
        .aliens_left   (aliens_left),
        .aliens_landed (aliens_landed),
        .state         (state),
        .run_en        (run_en),
        .formation_rst (formation_rst),
        .cannon_rst    (cannon_rst),
        .lives         (lives),
        .score         (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (formation_rst) n_frst++;
        if (cannon_rst)    n_crst++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            vsync = 1'b1;
            repeat (4) tick();
            vsync = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        repeat (5) tick();
        btn_start = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b0; btn_start = 1'b0; alien_hit = 1'b0;
        player_hit = 1'b0; aliens_left = 6'd10; aliens_landed = 1'b0;
        repeat (3) tick();
        checks++;
        if (state !== 3'd0 || run_en !== 1'b0 || lives !== 2'd0 || score !== 8'd0 ||
            formation_rst !== 1'b0 || cannon_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d run_en=%0b lives=%0d score=%0d frst=%0b crst=%0b, required 0 for all",
                     state, run_en, lives, score, formation_rst, cannon_rst);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_start();
        n_frst = 0; n_crst = 0;
        btn_start = 1'b1;
        repeat (3) tick();
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL start_early: state=%0d required 0", state);
        end
        tick();
        checks++;
        if (state !== 3'd1 || run_en !== 1'b1 || lives !== 2'd3 || score !== 8'd0) begin
            errors++;
            $display("FAIL start_enter: state=%0d run_en=%0b lives=%0d score=%0d, required 1/1/3/0",
                     state, run_en, lives, score);
        end
        checks++;
        if (formation_rst !== 1'b1 || cannon_rst !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: frst=%0b crst=%0b required 1/1", formation_rst, cannon_rst);
        end
        tick();
        btn_start = 1'b0;
        repeat (2) tick();
        checks++;
        if (n_frst !== 1 || n_crst !== 1) begin
            errors++;
            $display("FAIL start_pulse_count: frst=%0d crst=%0d required 1/1", n_frst, n_crst);
        end
    endtask

    task automatic test_score();
        alien_hit = 1'b1;
        repeat (5) tick();
        alien_hit = 1'b0;
        tick();
        checks++;
        if (score !== 8'd100) begin
            errors++; $display("FAIL score_100: score=%0d required 100", score);
        end
        alien_hit = 1'b1;
        repeat (20) tick();
        alien_hit = 1'b0;
        tick();
        checks++;
        if (score !== 8'd255 || lives !== 2'd3 || state !== 3'd1) begin
            errors++;
            $display("FAIL score_sat: score=%0d lives=%0d state=%0d required 255/3/1", score, lives, state);
        end
    endtask

    task automatic test_dying();
        for (int i = 0; i < 3; i++) begin
            n_frst = 0; n_crst = 0;
            player_hit = 1'b1;
            tick();
            player_hit = 1'b0;
            checks++;
            if (state !== 3'd2 || run_en !== 1'b0) begin
                errors++;
                $display("FAIL dying_enter[%0d]: state=%0d run_en=%0b required 2/0", i, state, run_en);
            end
            run_frames(3);
            checks++;
            if (state !== 3'd2) begin
                errors++; $display("FAIL dying_hold[%0d]: state=%0d required 2", i, state);
            end
            run_frames(1);
            checks++;
            if (state !== ((i < 2) ? 3'd1 : 3'd4) || lives !== 2'(2 - i) ||
                n_crst !== ((i < 2) ? 1 : 0) || n_frst !== 0) begin
                errors++;
                $display("FAIL dying_exit[%0d]: state=%0d lives=%0d crst=%0d frst=%0d required %0d/%0d/%0d/0",
                         i, state, lives, n_crst, n_frst, (i < 2) ? 1 : 4, 2 - i, (i < 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_gameover();
        btn_start = 1'b1;
        repeat (5) tick();
        btn_start = 1'b0;
        repeat (3) tick();
        checks++;
        if (state !== 3'd4 || score !== 8'd255) begin
            errors++;
            $display("FAIL gameover_start_ignored: state=%0d score=%0d required 4/255", state, score);
        end
        run_frames(4);
        checks++;
        if (state !== 3'd4) begin
            errors++; $display("FAIL gameover_hold: state=%0d required 4", state);
        end
        run_frames(1);
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL gameover_exit: state=%0d required 0", state);
        end
    endtask

    task automatic test_wave();
        press_start();
        checks++;
        if (state !== 3'd1 || score !== 8'd0 || lives !== 2'd3) begin
            errors++;
            $display("FAIL restart: state=%0d score=%0d lives=%0d required 1/0/3", state, score, lives);
        end
        aliens_left = 6'd0;
        tick();
        aliens_left = 6'd10;
        checks++;
        if (state !== 3'd3 || run_en !== 1'b0) begin
            errors++; $display("FAIL wave_enter: state=%0d run_en=%0b required 3/0", state, run_en);
        end
        n_frst = 0; n_crst = 0;
        run_frames(2);
        checks++;
        if (state !== 3'd3) begin
            errors++; $display("FAIL wave_hold: state=%0d required 3", state);
        end
        run_frames(1);
        checks++;
        if (state !== 3'd1 || run_en !== 1'b1 || n_frst !== 1 || n_crst !== 1) begin
            errors++;
            $display("FAIL wave_exit: state=%0d run_en=%0b frst=%0d crst=%0d required 1/1/1/1",
                     state, run_en, n_frst, n_crst);
        end
    endtask

    task automatic test_back_to_back();
        alien_hit = 1'b1; player_hit = 1'b1;
        tick();
        alien_hit = 1'b0; player_hit = 1'b0;
        checks++;
        if (score !== 8'd20 || state !== 3'd2) begin
            errors++; $display("FAIL hit_same_cycle: score=%0d state=%0d required 20/2", score, state);
        end
        alien_hit = 1'b1;
        tick();
        alien_hit = 1'b0;
        checks++;
        if (score !== 8'd20) begin
            errors++; $display("FAIL hit_ignored_dying: score=%0d required 20", score);
        end
        run_frames(4);
        aliens_landed = 1'b1; player_hit = 1'b1;
        tick();
        aliens_landed = 1'b0; player_hit = 1'b0;
        checks++;
        if (state !== 3'd4 || lives !== 2'd0 || run_en !== 1'b0) begin
            errors++;
            $display("FAIL landed_priority: state=%0d lives=%0d run_en=%0b required 4/0/0", state, lives, run_en);
        end
        run_frames(5);
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL landed_to_idle: state=%0d required 0", state);
        end
    endtask

`ifdef EXTRA_LIFE_EN
    task automatic test_extra_life();
        press_start();
        player_hit = 1'b1;
        tick();
        player_hit = 1'b0;
        run_frames(4);
        alien_hit = 1'b1;
        repeat (4) tick();
        alien_hit = 1'b0;
        checks++;
        if (score !== 8'd80 || lives !== 2'd2) begin
            errors++; $display("FAIL bonus_below: score=%0d lives=%0d required 80/2", score, lives);
        end
        alien_hit = 1'b1;
        tick();
        alien_hit = 1'b0;
        checks++;
        if (score !== 8'd100 || lives !== 2'd3) begin
            errors++; $display("FAIL bonus_award: score=%0d lives=%0d required 100/3", score, lives);
        end
        player_hit = 1'b1;
        tick();
        player_hit = 1'b0;
        run_frames(4);
        alien_hit = 1'b1;
        tick();
        alien_hit = 1'b0;
        checks++;
        if (score !== 8'd120 || lives !== 2'd2) begin
            errors++; $display("FAIL bonus_once: score=%0d lives=%0d required 120/2", score, lives);
        end
    endtask
`endif

    task automatic test_reset_mid_game();
        press_start();
        n_frst = 0; n_crst = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || lives !== 2'd0 || score !== 8'd0 || run_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: state=%0d lives=%0d score=%0d run_en=%0b required 0/0/0/0",
                     state, lives, score, run_en);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (n_frst !== 0 || n_crst !== 0 || state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_pulses: frst=%0d crst=%0d state=%0d required 0/0/0", n_frst, n_crst, state);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_score();
        test_dying();
        test_gameover();
        test_wave();
        test_back_to_back();
`ifdef EXTRA_LIFE_EN
        test_extra_life();
`endif
        test_reset_mid_game();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
